// File: rtl/counter_updown_mod_if.sv
// Control/status bundle for counter_updown_mod: count controls in, count and flags out.
interface counter_updown_mod_if #(
  parameter int unsigned WIDTH = 16
);
  logic             T;
  logic             UP;
  logic             LD;
  logic [WIDTH-1:0] D;
  logic             OVF_CLR;
  logic [WIDTH-1:0] Q;
  logic             TC;
  logic             OVF;

  modport master (output T, UP, LD, D, OVF_CLR, input Q, TC, OVF);
  modport slave  (input T, UP, LD, D, OVF_CLR, output Q, TC, OVF);
endinterface

// File: rtl/counter_updown_mod.sv
// Parametrised up/down counter with load, enable prescaler, TC pulse and sticky OVF.
// Define COUNTER_SATURATE_EN to hold at the range ends instead of wrapping.
module counter_updown_mod #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned MAX      = (2**WIDTH) - 1,
  parameter int unsigned PRESCALE = 1
) (
  input  logic CLK,
  input  logic CLR,
  counter_updown_mod_if.slave bus
);

  localparam int unsigned     PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MAX);
  localparam logic [PW-1:0]    PS_LAST = PW'(PRESCALE - 1);

  // Value Q takes on a terminal step in each direction.
`ifdef COUNTER_SATURATE_EN
  localparam logic [WIDTH-1:0] UP_END_Q = MAX_Q;
  localparam logic [WIDTH-1:0] DN_END_Q = '0;
`else
  localparam logic [WIDTH-1:0] UP_END_Q = '0;
  localparam logic [WIDTH-1:0] DN_END_Q = MAX_Q;
`endif

  logic [WIDTH-1:0] q_r, q_n;
  logic [PW-1:0]    pc_r, pc_n;
  logic             tc_r, tc_n;
  logic             ovf_r, ovf_n;
  logic             at_end;

  always_comb begin
    q_n    = q_r;
    pc_n   = pc_r;
    tc_n   = 1'b0;
    ovf_n  = ovf_r & ~bus.OVF_CLR;
    at_end = 1'b0;
    if (bus.LD) begin
      q_n  = (bus.D > MAX_Q) ? MAX_Q : bus.D;
      pc_n = '0;
    end else if (bus.T) begin
      if (pc_r == PS_LAST) begin
        pc_n = '0;
        if (bus.UP) begin
          at_end = (q_r == MAX_Q);
          q_n    = at_end ? UP_END_Q : q_r + WIDTH'(1);
        end else begin
          at_end = (q_r == '0);
          q_n    = at_end ? DN_END_Q : q_r - WIDTH'(1);
        end
      end else begin
        pc_n = pc_r + PW'(1);
      end
    end
    // Terminal step sets OVF even against a same-edge clear.
    if (at_end) begin
      tc_n  = 1'b1;
      ovf_n = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      q_r   <= '0;
      pc_r  <= '0;
      tc_r  <= 1'b0;
      ovf_r <= 1'b0;
    end else begin
      q_r   <= q_n;
      pc_r  <= pc_n;
      tc_r  <= tc_n;
      ovf_r <= ovf_n;
    end
  end

  assign bus.Q   = q_r;
  assign bus.TC  = tc_r;
  assign bus.OVF = ovf_r;

endmodule

// File: tb/tb_counter_updown_mod.sv
// Directed + random bench for counter_updown_mod across four parameter sets.
module tb_counter_updown_mod;

`ifdef COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        CLK, CLR;
  logic        t, up, ld, ovf_clr;
  logic [15:0] d;

  counter_updown_mod_if #(.WIDTH(16)) if0 ();
  counter_updown_mod_if #(.WIDTH(4))  if1 ();
  counter_updown_mod_if #(.WIDTH(4))  if2 ();
  counter_updown_mod_if #(.WIDTH(2))  if3 ();

  assign if0.T = t; assign if0.UP = up; assign if0.LD = ld; assign if0.OVF_CLR = ovf_clr; assign if0.D = d;
  assign if1.T = t; assign if1.UP = up; assign if1.LD = ld; assign if1.OVF_CLR = ovf_clr; assign if1.D = d[3:0];
  assign if2.T = t; assign if2.UP = up; assign if2.LD = ld; assign if2.OVF_CLR = ovf_clr; assign if2.D = d[3:0];
  assign if3.T = t; assign if3.UP = up; assign if3.LD = ld; assign if3.OVF_CLR = ovf_clr; assign if3.D = d[1:0];

  counter_updown_mod #(.WIDTH(16))                      dut0 (.CLK(CLK), .CLR(CLR), .bus(if0));
  counter_updown_mod #(.WIDTH(4), .MAX(9), .PRESCALE(1)) dut1 (.CLK(CLK), .CLR(CLR), .bus(if1));
  counter_updown_mod #(.WIDTH(4), .MAX(9), .PRESCALE(3)) dut2 (.CLK(CLK), .CLR(CLR), .bus(if2));
  counter_updown_mod #(.WIDTH(2), .MAX(1), .PRESCALE(1)) dut3 (.CLK(CLK), .CLR(CLR), .bus(if3));

  logic [15:0] q_obs   [4];
  logic        tc_obs  [4];
  logic        ovf_obs [4];
  assign q_obs[0] = if0.Q;          assign tc_obs[0] = if0.TC; assign ovf_obs[0] = if0.OVF;
  assign q_obs[1] = 16'(if1.Q);     assign tc_obs[1] = if1.TC; assign ovf_obs[1] = if1.OVF;
  assign q_obs[2] = 16'(if2.Q);     assign tc_obs[2] = if2.TC; assign ovf_obs[2] = if2.OVF;
  assign q_obs[3] = 16'(if3.Q);     assign tc_obs[3] = if3.TC; assign ovf_obs[3] = if3.OVF;

  // Reference model: count, enabled cycles since last step, flags.
  int          mx    [4] = '{65535, 9, 9, 1};
  int          ps    [4] = '{1, 1, 3, 1};
  int          dmask [4] = '{16'hFFFF, 16'hF, 16'hF, 16'h3};
  int          mq [4], mpc [4];
  bit          mtc [4], movf [4];
  int          npass = 0;
  int          ntot  = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      mq[i] = 0; mpc[i] = 0; mtc[i] = 0; movf[i] = 0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 4; i++) begin
      bit term;
      int dv;
      term = 0;
      mtc[i] = 0;
      if (ld) begin
        dv = int'(d) & dmask[i];
        mq[i]  = (dv > mx[i]) ? mx[i] : dv;
        mpc[i] = 0;
      end else if (t) begin
        mpc[i]++;
        if (mpc[i] == ps[i]) begin
          mpc[i] = 0;
          if (up) begin
            term  = (mq[i] == mx[i]);
            mq[i] = term ? (SAT ? mx[i] : 0) : mq[i] + 1;
          end else begin
            term  = (mq[i] == 0);
            mq[i] = term ? (SAT ? 0 : mx[i]) : mq[i] - 1;
          end
        end
      end
      if (ovf_clr) movf[i] = 0;
      if (term) begin
        mtc[i]  = 1;
        movf[i] = 1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 4; i++) begin
      ntot++;
      assert (q_obs[i] === 16'(mq[i])) npass++;
      else $error("FAIL %s dut%0d Q observed %0d expected %0d", tag, i, q_obs[i], mq[i]);
      ntot++;
      assert (tc_obs[i] === mtc[i]) npass++;
      else $error("FAIL %s dut%0d TC observed %b expected %b", tag, i, tc_obs[i], mtc[i]);
      ntot++;
      assert (ovf_obs[i] === movf[i]) npass++;
      else $error("FAIL %s dut%0d OVF observed %b expected %b", tag, i, ovf_obs[i], movf[i]);
    end
  endtask

  task automatic expect_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      @(posedge CLK);
      model_edge();
      @(negedge CLK);
      check_all(tag);
    end
  endtask

  // Called at a negedge: pulse CLR low between clock edges.
  task automatic async_reset(input string tag);
    CLR = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    #2;
    CLR = 1'b1;
  endtask

  initial begin
    CLR = 1'b0; t = 0; up = 1; ld = 0; ovf_clr = 0; d = '0;
    model_reset();
    @(negedge CLK);
    check_all("reset");
    @(negedge CLK);
    check_all("reset_hold");
    CLR = 1'b1;

    t = 1; up = 1;
    tick(5, "count");
    expect_eq("count_to5", q_obs[1], 16'd5);
    async_reset("async_mid_count");
    expect_eq("async_q", q_obs[1], 16'd0);

    tick(9, "upwrap");
    expect_eq("reach_max", q_obs[1], 16'd9);
    tick(1, "upwrap");
    expect_eq("wrap_q", q_obs[1], SAT ? 16'd9 : 16'd0);
    expect_eq("wrap_tc", 16'(tc_obs[1]), 16'd1);
    expect_eq("wrap_ovf", 16'(ovf_obs[1]), 16'd1);
    tick(1, "after_wrap");
    expect_eq("tc_once", 16'(tc_obs[1]), SAT ? 16'd1 : 16'd0);
    expect_eq("ovf_sticky", 16'(ovf_obs[1]), 16'd1);
    ovf_clr = 1;
    tick(1, "ovf_clr");
    ovf_clr = 0;
    expect_eq("ovf_cleared", 16'(ovf_obs[1]), SAT ? 16'd1 : 16'd0);

    ld = 1; d = 16'd0;
    tick(1, "load0");
    ld = 0; up = 0;
    tick(1, "downwrap");
    expect_eq("down_q", q_obs[1], SAT ? 16'd0 : 16'd9);
    expect_eq("down_tc", 16'(tc_obs[1]), 16'd1);
    tick(2, "down");
    expect_eq("down_to7", q_obs[1], SAT ? 16'd0 : 16'd7);
    up = 1;
    tick(1, "dir_change");
    expect_eq("dir_q", q_obs[1], SAT ? 16'd1 : 16'd8);

    ld = 1; d = 16'd0;
    tick(1, "ps_load");
    ld = 0;
    tick(3, "prescale");
    expect_eq("ps_first", q_obs[2], 16'd1);
    tick(1, "prescale");
    t = 0;
    tick(2, "ps_gap");
    t = 1;
    tick(1, "prescale");
    expect_eq("ps_delayed", q_obs[2], 16'd1);
    tick(1, "prescale");
    expect_eq("ps_step", q_obs[2], 16'd2);

    ld = 1; d = 16'd4;
    tick(1, "ld_pri");
    expect_eq("ld4_q1", q_obs[1], 16'd4);
    expect_eq("ld4_q2", q_obs[2], 16'd4);
    d = 16'd12;
    tick(1, "ld_clamp");
    expect_eq("ld12_clamp", q_obs[1], 16'd9);
    d = 16'd9;
    tick(1, "ld_on_wrap");
    expect_eq("ld_no_tc", 16'(tc_obs[1]), 16'd0);
    ld = 0;
    tick(1, "wrap_again");
    expect_eq("wrap2_tc", 16'(tc_obs[1]), 16'd1);
    ld = 1;
    tick(1, "reload");
    ld = 0; ovf_clr = 1;
    tick(1, "ovf_conflict");
    ovf_clr = 0;
    expect_eq("ovf_set_wins", 16'(ovf_obs[1]), 16'd1);

    for (int n = 0; n < 400; n++) begin
      t       = ($urandom % 4) != 0;
      if (($urandom % 8) == 0) up = ~up;
      ld      = ($urandom % 16) == 0;
      d       = 16'($urandom);
      ovf_clr = ($urandom % 8) == 0;
      if (($urandom % 97) == 0) async_reset("rand_async");
      tick(1, "random");
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
